// File: rtl/jstep_ctrl.sv
// jstep_ctrl: run/pause/halt controller for the CPU timing section.
// Produces the four-phase clock set and the 6-step one-hot stepper from the
// master clock. It also handles the run modes, halt requests and a
// completed-instruction counter.
module jstep_ctrl #(
  parameter int unsigned ICNT_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        mode,
  input  logic              go,
  input  logic              halt,
  output logic              wclk,
  output logic              wclkd,
  output logic              wclke,
  output logic              wclks,
  output logic [0:5]        bos,
  output logic              running,
  output logic              halted,
  output logic [ICNT_W-1:0] icnt
);

  typedef enum logic [1:0] {StPause, StRun, StHalted} state_e;

  state_e            state_q, state_d;
  logic [1:0]        p_q, p_d;
  logic [0:5]        bos_d;
  logic [ICNT_W-1:0] icnt_d;
  logic              halt_seen_q, halt_seen_d;
  logic              go_q;
  logic              go_rise;
  logic              last_step;
  logic              run_d;

  assign go_rise   = go & ~go_q;
  assign last_step = (bos == 6'b000001);
  assign run_d     = (state_d == StRun);

  // Next-state logic: phase counter, step rotation, counter and run decision.
  always_comb begin
    state_d     = state_q;
    p_d         = p_q;
    bos_d       = bos;
    icnt_d      = icnt;
    halt_seen_d = halt_seen_q;
    unique case (state_q)
      StPause: begin
        p_d = 2'd0;
        if (halt) begin
          state_d = StHalted;
          bos_d   = 6'b000000;
        end else if ((mode == 2'b00) || go_rise) begin
          state_d = StRun;
        end
      end
      StRun: begin
        // A halt mid-step is remembered so the step still completes cleanly.
        if (halt) halt_seen_d = 1'b1;
        if (p_q != 2'd3) begin
          p_d = p_q + 2'd1;
        end else begin
          p_d   = 2'd0;
          bos_d = {bos[5], bos[0:4]};
          if (last_step) icnt_d = icnt + ICNT_W'(1);
          if (halt_seen_q || halt) begin
            state_d = StHalted;
            bos_d   = 6'b000000;
          end else begin
            unique case (mode)
              2'b00:   state_d = StRun;
              2'b10:   state_d = last_step ? StPause : StRun;
              default: state_d = StPause;
            endcase
          end
        end
      end
      StHalted: begin
        state_d = StHalted;
      end
      default: begin
        state_d = StPause;
      end
    endcase
  end

  // State registers; clock outputs are registered from next state/phase so
  // they are glitch-free and have no path from the inputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StPause;
      p_q         <= 2'd0;
      bos         <= 6'b100000;
      icnt        <= '0;
      halt_seen_q <= 1'b0;
      go_q        <= 1'b0;
      wclk        <= 1'b0;
      wclkd       <= 1'b0;
      wclke       <= 1'b0;
      wclks       <= 1'b0;
      running     <= 1'b0;
      halted      <= 1'b0;
    end else begin
      state_q     <= state_d;
      p_q         <= p_d;
      bos         <= bos_d;
      icnt        <= icnt_d;
      halt_seen_q <= halt_seen_d;
      go_q        <= go;
      wclk        <= run_d & ~p_d[1];
      wclkd       <= run_d & (p_d[1] ^ p_d[0]);
      wclke       <= run_d & (p_d != 2'd3);
      wclks       <= run_d & (p_d == 2'd1);
      running     <= run_d;
      halted      <= (state_d == StHalted);
    end
  end

endmodule

// File: tb/tb_jstep_ctrl.sv
// Self-checking bench for jstep_ctrl: a step-index reference model pushes the
// expected outputs per cycle, and the queue is popped after each clock edge.
module tb_jstep_ctrl;

  localparam int unsigned IW = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [1:0]    mode = 2'b00;
  logic          go = 1'b0;
  logic          halt = 1'b0;
  logic          wclk, wclkd, wclke, wclks;
  logic [0:5]    bos;
  logic          running, halted;
  logic [IW-1:0] icnt;

  jstep_ctrl #(.ICNT_W(IW)) dut (
    .clk     (clk),
    .reset   (reset),
    .mode    (mode),
    .go      (go),
    .halt    (halt),
    .wclk    (wclk),
    .wclkd   (wclkd),
    .wclke   (wclke),
    .wclks   (wclks),
    .bos     (bos),
    .running (running),
    .halted  (halted),
    .icnt    (icnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          wclk;
    logic          wclkd;
    logic          wclke;
    logic          wclks;
    logic [5:0]    bos;
    logic          running;
    logic          halted;
    logic [IW-1:0] icnt;
  } obs_t;

  obs_t exp_q[$];
  int   n_vec = 0;
  int   n_bad = 0;
  int   run_cnt = 0;
  int   cyc_n = 0;

  // Reference model: 0=pause 1=run 2=halted; step 0..5, 6 = none.
  int   m_st, m_p, m_step, m_icnt, m_hs;
  bit   m_goq;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_step(input bit r, input logic [1:0] md, input bit g, input bit h);
    bit last;
    if (r) begin
      m_st = 0; m_p = 0; m_step = 0; m_icnt = 0; m_hs = 0; m_goq = 0;
    end else begin
      case (m_st)
        0: begin
          if (h) begin
            m_st = 2; m_step = 6;
          end else if (md == 2'b00 || (g && !m_goq)) begin
            m_st = 1; m_p = 0;
          end
        end
        1: begin
          if (m_p < 3) begin
            m_p++;
            if (h) m_hs = 1;
          end else begin
            last   = (m_step == 5);
            m_p    = 0;
            m_step = (m_step + 1) % 6;
            if (last) m_icnt = (m_icnt + 1) % (1 << IW);
            if (m_hs != 0 || h) begin
              m_st = 2; m_step = 6;
            end else if (md == 2'b01 || md == 2'b11 || (md == 2'b10 && last)) begin
              m_st = 0;
            end
          end
        end
        default: ;
      endcase
      m_goq = g;
    end
  endtask

  function automatic obs_t model_out();
    obs_t       o;
    logic [5:0] first = 6'b100000;
    bit         rn = (m_st == 1);
    o.wclk    = rn && (m_p < 2);
    o.wclkd   = rn && (m_p == 1 || m_p == 2);
    o.wclke   = rn && (m_p != 3);
    o.wclks   = rn && (m_p == 1);
    o.bos     = (m_step == 6) ? 6'b000000 : (first >> m_step);
    o.running = rn;
    o.halted  = (m_st == 2);
    o.icnt    = m_icnt[IW-1:0];
    return o;
  endfunction

  function automatic obs_t dut_out();
    obs_t o;
    o.wclk    = wclk;
    o.wclkd   = wclkd;
    o.wclke   = wclke;
    o.wclks   = wclks;
    o.bos     = bos;
    o.running = running;
    o.halted  = halted;
    o.icnt    = icnt;
    return o;
  endfunction

  // One clock: drive inputs, push the model's expectation, compare after the edge.
  task automatic cyc(input bit r, input logic [1:0] md, input bit g, input bit h);
    @(negedge clk);
    reset = r; mode = md; go = g; halt = h;
    model_step(r, md, g, h);
    exp_q.push_back(model_out());
    @(posedge clk);
    #1;
    cyc_n++;
    if (running) run_cnt++;
    check_val($sformatf("cyc%0d", cyc_n), dut_out(), exp_q.pop_front());
  endtask

  initial begin
    bit found;

    // Reset state, then free-run.
    cyc(1, 2'b00, 0, 0);
    check_val("rst_bos", bos, 6'b100000);
    check_val("rst_flags", {wclk, wclkd, wclke, wclks, running, halted}, 6'b0);
    check_val("rst_icnt", icnt, 0);
    for (int i = 1; i <= 50; i++) begin
      cyc(0, 2'b00, 0, 0);
      if (i == 1)  check_val("first_wclk", {wclk, wclkd, running}, 3'b101);
      if (i == 24) check_val("icnt_before1", icnt, 0);
      if (i == 25) check_val("icnt_1", icnt, 1);
      if (i == 49) check_val("icnt_2", icnt, 2);
    end

    // Single-step; the go pulse inside the run window is ignored.
    cyc(1, 2'b01, 0, 0);
    cyc(0, 2'b01, 0, 0);
    run_cnt = 0;
    cyc(0, 2'b01, 1, 0);
    cyc(0, 2'b01, 0, 0);
    cyc(0, 2'b01, 1, 0);
    for (int i = 0; i < 6; i++) cyc(0, 2'b01, 0, 0);
    check_val("ss_runs", run_cnt, 4);
    check_val("ss_bos", bos, 6'b010000);
    run_cnt = 0;
    cyc(0, 2'b11, 1, 0);
    for (int i = 0; i < 6; i++) cyc(0, 2'b11, 0, 0);
    check_val("ss2_runs", run_cnt, 4);
    check_val("ss2_bos", bos, 6'b001000);

    // Single-instruction from step 1, then from step 4.
    cyc(1, 2'b10, 0, 0);
    cyc(0, 2'b10, 0, 0);
    run_cnt = 0;
    cyc(0, 2'b10, 1, 0);
    for (int i = 0; i < 30; i++) cyc(0, 2'b10, 0, 0);
    check_val("si_runs", run_cnt, 24);
    check_val("si_icnt", icnt, 1);
    check_val("si_bos", {bos, running}, 7'b1000000);
    for (int s = 0; s < 3; s++) begin
      cyc(0, 2'b01, 1, 0);
      for (int i = 0; i < 5; i++) cyc(0, 2'b01, 0, 0);
    end
    check_val("si_at4", bos, 6'b000100);
    run_cnt = 0;
    cyc(0, 2'b10, 1, 0);
    for (int i = 0; i < 16; i++) cyc(0, 2'b10, 0, 0);
    check_val("si2_runs", run_cnt, 12);
    check_val("si2_icnt", icnt, 2);
    check_val("si2_bos", bos, 6'b100000);

    // Halt at step 3 p1: the step finishes before halting.
    cyc(1, 2'b00, 0, 0);
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      cyc(0, 2'b00, 0, 0);
      found = (bos == 6'b001000) && wclks;
    end
    check_val("reach_s3p1", found, 1);
    cyc(0, 2'b00, 0, 1);
    check_val("halt_p2", {wclk, wclkd, running, halted}, 4'b0110);
    cyc(0, 2'b00, 0, 0);
    check_val("halt_p3", {wclk, wclkd, wclke, running, halted}, 5'b00010);
    cyc(0, 2'b00, 0, 0);
    check_val("halted", {wclk, wclkd, wclke, wclks, bos, running, halted}, 12'b000000000001);
    cyc(0, 2'b00, 1, 0);
    cyc(0, 2'b00, 0, 0);
    cyc(0, 2'b01, 1, 0);
    check_val("halt_sticky", {running, halted}, 2'b01);
    cyc(1, 2'b01, 0, 0);
    check_val("halt_rst", {bos, running, halted}, 8'b10000000);

    // Reset mid-step at step 4 p2 with a nonzero counter.
    cyc(1, 2'b00, 0, 0);
    found = 0;
    for (int i = 0; i < 60 && !found; i++) begin
      cyc(0, 2'b00, 0, 0);
      found = (icnt == 1) && (bos == 6'b000100) && wclkd && !wclk;
    end
    check_val("reach_s4p2", found, 1);
    cyc(1, 2'b00, 0, 0);
    check_val("midrst_bos", bos, 6'b100000);
    check_val("midrst_misc", {icnt, wclk, wclkd, wclke, wclks, running, halted}, 0);

    // Counter wrap with a 2-bit counter.
    for (int i = 1; i <= 97; i++) begin
      cyc(0, 2'b00, 0, 0);
      if (i == 73) check_val("icnt_3", icnt, 3);
      if (i == 97) check_val("icnt_wrap", icnt, 0);
    end

    // Halt beats a go rising edge in PAUSE.
    cyc(1, 2'b01, 0, 0);
    cyc(0, 2'b01, 0, 0);
    cyc(0, 2'b01, 1, 1);
    check_val("prio", {bos, running, halted}, 8'b00000001);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
